// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator between CPU datapath and byte-lane data memory
// One request in flight at a time; the pipeline stalls until the response pulse.
module mem_access_unit #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_signed,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_misalign,
  output logic        stall,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        cpu_ready_q;
  logic        cpu_rvalid_q;
  logic        cpu_misalign_q;
  logic [31:0] cpu_rdata_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic        misalign_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] shifted_d;
  logic [31:0] rdata_d;

  // Lane steering and alignment check, evaluated on the live request at accept
  always_comb begin
    misalign_d = 1'b0;
    be_d       = 4'h0;
    wdata_d    = 32'h0;
    case (cpu_size)
      2'd0: begin
        be_d    = 4'b0001 << cpu_addr[1:0];
        wdata_d = {4{cpu_wdata[7:0]}};
      end
      2'd1: begin
        be_d       = cpu_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d    = {2{cpu_wdata[15:0]}};
        misalign_d = cpu_addr[0];
      end
      2'd2: begin
        be_d       = 4'hF;
        wdata_d    = cpu_wdata;
        misalign_d = |cpu_addr[1:0];
      end
      default: misalign_d = 1'b1;
    endcase
  end

  always_comb begin
    shifted_d = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    rdata_d = {{24{signed_q & shifted_d[7]}}, shifted_d[7:0]};
      2'd1:    rdata_d = {{16{signed_q & shifted_d[15]}}, shifted_d[15:0]};
      default: rdata_d = shifted_d;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= 4'h0;
      off_q          <= 2'b00;
      size_q         <= 2'b00;
      signed_q       <= 1'b0;
      cpu_ready_q    <= 1'b1;
      cpu_rvalid_q   <= 1'b0;
      cpu_misalign_q <= 1'b0;
      cpu_rdata_q    <= 32'h0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_be_q       <= 4'h0;
      mem_addr_q     <= 32'h0;
      mem_wdata_q    <= 32'h0;
    end else begin
      cpu_rvalid_q   <= 1'b0;
      cpu_misalign_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cpu_valid) begin
            off_q       <= cpu_addr[1:0];
            size_q      <= cpu_size;
            signed_q    <= cpu_signed;
            cpu_ready_q <= 1'b0;
            if (misalign_d) begin
              state_q        <= S_RESP;
              cpu_rvalid_q   <= 1'b1;
              cpu_misalign_q <= 1'b1;
              cpu_rdata_q    <= 32'h0;
            end else begin
              state_q     <= S_REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= cpu_wr;
              mem_be_q    <= be_d;
              mem_addr_q  <= {cpu_addr[31:2], 2'b00};
              mem_wdata_q <= wdata_d;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            if (mem_we_q) begin
              state_q      <= S_RESP;
              cpu_rvalid_q <= 1'b1;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'h0) begin
            cpu_rdata_q  <= rdata_d;
            cpu_rvalid_q <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'h1;
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          cpu_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          cpu_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cpu_ready    = cpu_ready_q;
  assign cpu_rvalid   = cpu_rvalid_q;
  assign cpu_misalign = cpu_misalign_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign stall        = cpu_valid & ~cpu_ready_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_be       = mem_be_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;

endmodule
